// File: rtl/reg_dump_uart_tx_pkg.sv
// Shared definitions for the register-dump UART reader: ASCII codes,
// line length, FSM state encoding and small character helpers.
package reg_dump_uart_tx_pkg;

    localparam logic [7:0] ASCII_X     = 8'h78;
    localparam logic [7:0] ASCII_EQ    = 8'h3D;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_0     = 8'h30;
    // 'A' minus 10, so nibble 10 maps to 'A'
    localparam logic [7:0] ASCII_A_M10 = 8'h37;

    localparam int         LINE_BYTES  = 14;
    localparam logic [3:0] LAST_BYTE   = 4'(LINE_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_CAPTURE,
        ST_SEND,
        ST_WAIT_TX,
        ST_NEXT,
        ST_DONE
    } state_e;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10)
            return ASCII_0 + {4'd0, n};
        else
            return ASCII_A_M10 + {4'd0, n};
    endfunction

    // Tens digit by compare chain; index never exceeds 31.
    function automatic logic [1:0] dec_tens(input logic [4:0] v);
        if (v >= 5'd30)
            return 2'd3;
        else if (v >= 5'd20)
            return 2'd2;
        else if (v >= 5'd10)
            return 2'd1;
        else
            return 2'd0;
    endfunction

    function automatic logic [3:0] dec_ones(input logic [4:0] v);
        logic [4:0] r;
        unique case (dec_tens(v))
            2'd3:    r = v - 5'd30;
            2'd2:    r = v - 5'd20;
            2'd1:    r = v - 5'd10;
            default: r = v;
        endcase
        return r[3:0];
    endfunction

endpackage

// File: rtl/reg_dump_uart_tx_uart_tx.sv
// uart_tx: 8N1 serialiser, LSB first, idle high.
// Ports: clk, rstn (sync, active-low), tx_valid/tx_data in,
//        tx_ready out (high only when idle), tx serial out.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    logic          busy_q, busy_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    // Remaining bits after the start bit: data then stop.
    logic [8:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    always_comb begin
        busy_d  = busy_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        if (!busy_q) begin
            if (tx_valid) begin
                busy_d  = 1'b1;
                tx_d    = 1'b0;
                shift_d = {1'b1, tx_data};
                baud_d  = '0;
                bit_d   = 4'd0;
            end
        end else if (baud_q == BAUD_LAST) begin
            baud_d = '0;
            if (bit_q == 4'd9) begin
                busy_d = 1'b0;
                tx_d   = 1'b1;
            end else begin
                tx_d    = shift_q[0];
                shift_d = {1'b0, shift_q[8:1]};
                bit_d   = bit_q + 4'd1;
            end
        end else begin
            baud_d = baud_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy_q  <= 1'b0;
            baud_q  <= '0;
            bit_q   <= 4'd0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            busy_q  <= busy_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx_ready = ~busy_q;
    assign tx       = tx_q;

endmodule

// File: rtl/reg_dump_uart_tx.sv
// Reads x0..x(NUM_REGS-1) over the regfile debug port and prints each as
// "xNN=HHHHHHHH\r\n" on a UART line.
// Ports: clk, rstn (sync, active-low), start (level, sampled in IDLE),
//        reg_sel/reg_data (debug port), tx (serial), busy, done (pulse).
module reg_dump_uart_tx
    import reg_dump_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_REGS     = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    state_e      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [4:0]  reg_sel_q, reg_sel_d;
    logic [3:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] data_q, data_d;

    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_byte;

    logic [1:0]  tens;
    logic [3:0]  ones;
    logic [2:0]  nib_sel;
    logic [3:0]  nib;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        reg_sel_d  = reg_sel_q;
        byte_cnt_d = byte_cnt_q;
        data_d     = data_q;
        tx_valid   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SELECT;
                    idx_d     = 5'd0;
                    reg_sel_d = 5'd0;
                end
            end
            ST_SELECT: state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                data_d     = reg_data;
                byte_cnt_d = 4'd0;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                if (tx_ready)
                    state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (tx_ready) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d = ST_NEXT;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                        state_d    = ST_SEND;
                    end
                end
            end
            ST_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d     = idx_q + 5'd1;
                    reg_sel_d = idx_q + 5'd1;
                    state_d   = ST_SELECT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            idx_q      <= 5'd0;
            reg_sel_q  <= 5'd0;
            byte_cnt_q <= 4'd0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            reg_sel_q  <= reg_sel_d;
            byte_cnt_q <= byte_cnt_d;
            data_q     <= data_d;
        end
    end

    // Byte 4 carries data_q[31:28], byte 11 carries data_q[3:0].
    always_comb begin
        tens    = dec_tens(idx_q);
        ones    = dec_ones(idx_q);
        nib_sel = 3'(byte_cnt_q - 4'd4);
        nib     = data_q[5'd28 - {nib_sel, 2'b00} +: 4];
        tx_byte = ASCII_LF;
        unique case (byte_cnt_q)
            4'd0:    tx_byte = ASCII_X;
            4'd1:    tx_byte = ASCII_0 + {6'd0, tens};
            4'd2:    tx_byte = ASCII_0 + {4'd0, ones};
            4'd3:    tx_byte = ASCII_EQ;
            4'd12:   tx_byte = ASCII_CR;
            4'd13:   tx_byte = ASCII_LF;
            default: tx_byte = hex_char(nib);
        endcase
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk     (clk),
        .rstn    (rstn),
        .tx_valid(tx_valid),
        .tx_data (tx_byte),
        .tx_ready(tx_ready),
        .tx      (tx)
    );

    assign reg_sel = reg_sel_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);

endmodule
